mux_scan_nch: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer. Successor to the fixed 8:1 4-bit combinational mux.
- Adds a registered output and a channel-index output.
- Adds an auto-scan mode that steps through enabled channels with a programmable dwell time.
- Feeds display/monitor paths that time-share one datapath across several sources.

---
 rtl/mux_scan_nch_pkg.sv | 21 ++
 rtl/mux_next_en.sv | 46 ++++
 rtl/mux_scan_nch.sv | 169 ++++++++++++++++
 tb/tb_mux_scan_nch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_nch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_nch_pkg
//  Description : Shared constants and FSM state encoding for the N-channel
//                registered scanning multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_nch_pkg;

    // Values of the mode input
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Top-level FSM
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

endpackage : mux_scan_nch_pkg
`default_nettype wire

// File: rtl/mux_next_en.sv
`default_nettype none
// ============================================================================
//  Module      : mux_next_en
//  Description : Combinational circular priority finder. Returns the first
//                enabled channel strictly after cur, searching upward modulo
//                NCH. Passing cur = NCH-1 yields the lowest enabled channel.
//  Ports       : ch_en - per-channel enables
//                cur   - starting channel (excluded from the search first)
//                next  - next enabled channel (cur itself if it is the only one)
//                wrap  - next <= cur, i.e. the search went past NCH-1
//                none  - no channel enabled; next is 0
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_next_en
    import mux_scan_nch_pkg::*;
#(
    parameter int NCH    = 8,
    parameter int SWIDTH = 3
) (
    input  logic [NCH-1:0]    ch_en,
    input  logic [SWIDTH-1:0] cur,
    output logic [SWIDTH-1:0] next,
    output logic              wrap,
    output logic              none
);

    logic [SWIDTH-1:0] w_idx;

    // Walk from the farthest candidate (cur+NCH == cur) back to the nearest
    // (cur+1); the last hit therefore wins, giving the closest enabled channel.
    always_comb begin
        next  = '0;
        w_idx = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_idx = SWIDTH'((int'(cur) + i) % NCH);
            if (ch_en[w_idx]) begin
                next = w_idx;
            end
        end
    end

    assign wrap = (next <= cur);
    assign none = ~|ch_en;

endmodule : mux_next_en
`default_nettype wire

// File: rtl/mux_scan_nch.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_nch
//  Description : Parametrised N-channel, W-bit registered multiplexer with a
//                manual-select mode and an auto-scan mode that steps through
//                enabled channels, holding each for dwell+1 cycles.
//  Ports       : clk     - rising-edge clock
//                reset   - synchronous active-high reset
//                i_data  - packed channel data, channel k at [k*WIDTH +: WIDTH]
//                ch_en   - per-channel enables (scan mode only)
//                mode    - 0 manual select, 1 auto-scan
//                sel     - manual channel select
//                dwell   - extra cycles spent on each channel when scanning
//                o       - registered selected data
//                o_ch    - index of the channel currently driving o
//                o_valid - o holds valid data from channel o_ch
//                o_wrap  - one-cycle pulse on the first output cycle after
//                          the scan wraps to a lower-or-equal channel
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_nch
    import mux_scan_nch_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NCH    = 8,
    parameter int SWIDTH = 3,
    parameter int DWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] i_data,
    input  logic [NCH-1:0]       ch_en,
    input  logic                 mode,
    input  logic [SWIDTH-1:0]    sel,
    input  logic [DWIDTH-1:0]    dwell,
    output logic [WIDTH-1:0]     o,
    output logic [SWIDTH-1:0]    o_ch,
    output logic                 o_valid,
    output logic                 o_wrap
);

    localparam logic [SWIDTH-1:0] c_last_ch = SWIDTH'(NCH - 1);

    state_t              r_state;
    logic [SWIDTH-1:0]   r_cur;
    logic [DWIDTH-1:0]   r_cnt;
    logic                r_pend;     // advance just wrapped; flag it on the next output
    logic [WIDTH-1:0]    r_o;
    logic [SWIDTH-1:0]   r_ch;
    logic                r_valid;
    logic                r_wrap;

    logic [SWIDTH-1:0]   w_find_cur;
    logic [SWIDTH-1:0]   w_next;
    logic                w_wrap;
    logic                w_none;
    logic                w_sel_ok;
    logic [WIDTH-1:0]    w_man_o;
    logic [WIDTH-1:0]    w_scan_o;

    function automatic logic [WIDTH-1:0] pick(input logic [NCH*WIDTH-1:0] d,
                                              input logic [SWIDTH-1:0]    idx);
        pick = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(idx) == k) begin
                pick = d[k*WIDTH +: WIDTH];
            end
        end
    endfunction

    // One finder serves both uses: in IDLE it looks for the lowest enabled
    // channel (search after NCH-1), in SCAN for the successor of r_cur.
    assign w_find_cur = (r_state == ST_SCAN) ? r_cur : c_last_ch;

    mux_next_en #(
        .NCH    (NCH),
        .SWIDTH (SWIDTH)
    ) u_next_en (
        .ch_en (ch_en),
        .cur   (w_find_cur),
        .next  (w_next),
        .wrap  (w_wrap),
        .none  (w_none)
    );

    // Out-of-range manual selects produce zero data and no valid.
    assign w_sel_ok = (int'(sel) < NCH);
    assign w_man_o  = w_sel_ok ? pick(i_data, sel) : '0;
    assign w_scan_o = pick(i_data, r_cur);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_o     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wrap <= 1'b0;
                    r_pend <= 1'b0;
                    if (mode == MODE_MANUAL) begin
                        r_o     <= w_man_o;
                        r_ch    <= sel;
                        r_valid <= w_sel_ok;
                    end else begin
                        r_o     <= '0;
                        r_ch    <= '0;
                        r_valid <= 1'b0;
                        if (!w_none) begin
                            r_state <= ST_SCAN;
                            r_cur   <= w_next;
                            r_cnt   <= '0;
                        end
                    end
                end

                ST_SCAN: begin
                    if (mode == MODE_MANUAL) begin
                        // Leaving scan still performs this edge's manual update.
                        r_state <= ST_IDLE;
                        r_o     <= w_man_o;
                        r_ch    <= sel;
                        r_valid <= w_sel_ok;
                        r_wrap  <= 1'b0;
                        r_pend  <= 1'b0;
                    end else if (w_none) begin
                        r_state <= ST_IDLE;
                        r_o     <= '0;
                        r_ch    <= r_cur;
                        r_valid <= 1'b0;
                        r_wrap  <= 1'b0;
                        r_pend  <= 1'b0;
                    end else begin
                        r_o     <= w_scan_o;
                        r_ch    <= r_cur;
                        r_valid <= ch_en[r_cur];
                        r_wrap  <= r_pend;
                        // dwell is compared live; a counter already past a
                        // shrunken dwell runs round through 2^DWIDTH.
                        if (r_cnt == dwell) begin
                            r_cnt  <= '0;
                            r_cur  <= w_next;
                            r_pend <= w_wrap;
                        end else begin
                            r_cnt  <= r_cnt + DWIDTH'(1);
                            r_pend <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o       = r_o;
    assign o_ch    = r_ch;
    assign o_valid = r_valid;
    assign o_wrap  = r_wrap;

endmodule : mux_scan_nch
`default_nettype wire

// File: tb/tb_mux_scan_nch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_scan_nch
//  Description : Self-checking bench for mux_scan_nch (NCH=8, WIDTH=4,
//                channel k carries k+1). Expected outputs are queued as each
//                cycle's stimulus is applied and compared one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_nch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_data;
    logic [7:0]  ch_en;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  dwell;
    logic [3:0]  o;
    logic [2:0]  o_ch;
    logic        o_valid;
    logic        o_wrap;

    typedef struct packed {
        logic [3:0] o;
        logic [2:0] ch;
        logic       v;
        logic       w;
        logic       chk_ch;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mux_scan_nch #(
        .WIDTH  (4),
        .NCH    (8),
        .SWIDTH (3),
        .DWIDTH (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .ch_en   (ch_en),
        .mode    (mode),
        .sel     (sel),
        .dwell   (dwell),
        .o       (o),
        .o_ch    (o_ch),
        .o_valid (o_valid),
        .o_wrap  (o_wrap)
    );

    task automatic push(input int o_e, input int ch_e, input logic v_e,
                        input logic w_e, input logic chk);
        exp_t e;
        e.o      = 4'(o_e);
        e.ch     = 3'(ch_e);
        e.v      = v_e;
        e.w      = w_e;
        e.chk_ch = chk;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1; mode = 1'b0; sel = 3'd5; ch_en = 8'h00; dwell = 8'd0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) reset = 1'b0;
            if (i < 2) push(0, 0, 1'b0, 1'b0, 1'b1);
            else       push(6, 5, 1'b1, 1'b0, 1'b1);
            tick();
            e = sbq.pop_front();
            n_vec++;
            if ({o, o_valid, o_wrap} !== {e.o, e.v, e.w} || (e.chk_ch && o_ch !== e.ch)) begin
                n_err++;
                $display("FAIL reset cyc%0d: got o=%0d ch=%0d v=%0b w=%0b, want o=%0d ch=%0d v=%0b w=%0b",
                         i, o, o_ch, o_valid, o_wrap, e.o, e.ch, e.v, e.w);
            end
        end
    endtask

    task automatic test_manual_sweep();
        exp_t e;
        mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            push(k + 1, k, 1'b1, 1'b0, 1'b1);
            tick();
            e = sbq.pop_front();
            n_vec++;
            if ({o, o_valid, o_wrap} !== {e.o, e.v, e.w} || (e.chk_ch && o_ch !== e.ch)) begin
                n_err++;
                $display("FAIL manual sel%0d: got o=%0d ch=%0d v=%0b w=%0b, want o=%0d ch=%0d v=%0b w=%0b",
                         k, o, o_ch, o_valid, o_wrap, e.o, e.ch, e.v, e.w);
            end
        end
    endtask

    task automatic test_scan_multi();
        exp_t e;
        int   seq[16] = '{0, 0, 0, 2, 2, 2, 5, 5, 5, 7, 7, 7, 0, 0, 0, 2};
        mode = 1'b1; ch_en = 8'b1010_0101; dwell = 8'd2;
        for (int i = -1; i < 16; i++) begin
            if (i < 0) push(0, 0, 1'b0, 1'b0, 1'b0);     // IDLE->SCAN entry edge
            else       push(seq[i] + 1, seq[i], 1'b1, (i == 12), 1'b1);
            tick();
            e = sbq.pop_front();
            n_vec++;
            if ({o, o_valid, o_wrap} !== {e.o, e.v, e.w} || (e.chk_ch && o_ch !== e.ch)) begin
                n_err++;
                $display("FAIL scan_multi cyc%0d: got o=%0d ch=%0d v=%0b w=%0b, want o=%0d ch=%0d v=%0b w=%0b",
                         i, o, o_ch, o_valid, o_wrap, e.o, e.ch, e.v, e.w);
            end
        end
    endtask

    task automatic test_single_channel();
        exp_t e;
        for (int i = -2; i < 6; i++) begin
            if (i == -2) begin
                mode = 1'b0; sel = 3'd0;
                push(1, 0, 1'b1, 1'b0, 1'b1);
            end else if (i == -1) begin
                mode = 1'b1; ch_en = 8'b0001_0000; dwell = 8'd0;
                push(0, 0, 1'b0, 1'b0, 1'b0);
            end else begin
                // Only channel 4: every advance returns to itself and wraps.
                push(5, 4, 1'b1, (i != 0), 1'b1);
            end
            tick();
            e = sbq.pop_front();
            n_vec++;
            if ({o, o_valid, o_wrap} !== {e.o, e.v, e.w} || (e.chk_ch && o_ch !== e.ch)) begin
                n_err++;
                $display("FAIL single cyc%0d: got o=%0d ch=%0d v=%0b w=%0b, want o=%0d ch=%0d v=%0b w=%0b",
                         i, o, o_ch, o_valid, o_wrap, e.o, e.ch, e.v, e.w);
            end
        end
    endtask

    task automatic test_chen_off();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin ch_en = 8'h00; push(0, 0, 1'b0, 1'b0, 1'b0); end
                1: push(0, 0, 1'b0, 1'b0, 1'b0);
                2: begin ch_en = 8'h01; push(0, 0, 1'b0, 1'b0, 1'b0); end
                3: push(1, 0, 1'b1, 1'b0, 1'b1);
                default: push(1, 0, 1'b1, 1'b1, 1'b1);
            endcase
            tick();
            e = sbq.pop_front();
            n_vec++;
            if ({o, o_valid, o_wrap} !== {e.o, e.v, e.w} || (e.chk_ch && o_ch !== e.ch)) begin
                n_err++;
                $display("FAIL chen_off cyc%0d: got o=%0d ch=%0d v=%0b w=%0b, want o=%0d ch=%0d v=%0b w=%0b",
                         i, o, o_ch, o_valid, o_wrap, e.o, e.ch, e.v, e.w);
            end
        end
    endtask

    task automatic test_disable_cur();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin dwell = 8'd3; push(1, 0, 1'b1, 1'b1, 1'b1); end
                1: begin ch_en = 8'b0000_0100; push(1, 0, 1'b0, 1'b0, 1'b1); end
                2, 3: push(1, 0, 1'b0, 1'b0, 1'b1);   // no early skip
                default: push(3, 2, 1'b1, 1'b0, 1'b1);
            endcase
            tick();
            e = sbq.pop_front();
            n_vec++;
            if ({o, o_valid, o_wrap} !== {e.o, e.v, e.w} || (e.chk_ch && o_ch !== e.ch)) begin
                n_err++;
                $display("FAIL disable_cur cyc%0d: got o=%0d ch=%0d v=%0b w=%0b, want o=%0d ch=%0d v=%0b w=%0b",
                         i, o, o_ch, o_valid, o_wrap, e.o, e.ch, e.v, e.w);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        int   pre[7]  = '{0, 0, 0, 2, 2, 2, 5};
        int   post[4] = '{0, 0, 0, 2};
        for (int i = 0; i < 15; i++) begin
            if (i == 0) begin
                mode = 1'b0; sel = 3'd3;
                push(4, 3, 1'b1, 1'b0, 1'b1);
            end else if (i == 1) begin
                mode = 1'b1; ch_en = 8'b1010_0101; dwell = 8'd2;
                push(0, 0, 1'b0, 1'b0, 1'b0);
            end else if (i < 9) begin
                push(pre[i-2] + 1, pre[i-2], 1'b1, 1'b0, 1'b1);
            end else if (i == 9) begin
                reset = 1'b1;                          // cur=5, cnt=1 here
                push(0, 0, 1'b0, 1'b0, 1'b1);
            end else if (i == 10) begin
                reset = 1'b0;
                push(0, 0, 1'b0, 1'b0, 1'b0);
            end else begin
                push(post[i-11] + 1, post[i-11], 1'b1, 1'b0, 1'b1);
            end
            tick();
            e = sbq.pop_front();
            n_vec++;
            if ({o, o_valid, o_wrap} !== {e.o, e.v, e.w} || (e.chk_ch && o_ch !== e.ch)) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got o=%0d ch=%0d v=%0b w=%0b, want o=%0d ch=%0d v=%0b w=%0b",
                         i, o, o_ch, o_valid, o_wrap, e.o, e.ch, e.v, e.w);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            i_data[k*4 +: 4] = 4'(k + 1);
        end
        reset = 1'b1; mode = 1'b0; sel = 3'd0; ch_en = 8'h00; dwell = 8'd0;
        test_reset();
        test_manual_sweep();
        test_scan_multi();
        test_single_channel();
        test_chen_off();
        test_disable_cur();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_mux_scan_nch
`default_nettype wire
